// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
//   - FSM state encoding (two bits, IDLE/LOAD/RUN/DONE)
//   - datapath operation encoding (md_op)
//   - default iteration counts and counter width
package multdiv_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEF_MULT_CYCLES = 32;
  localparam int DEF_DIV_CYCLES  = 32;
  localparam int DEF_CNT_W       = 6;

endpackage

// File: rtl/md_cycle_counter.sv
// Iteration counter for the multiply/divide sequencer.
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous active-low reset
//   clear    - synchronous clear to zero (wins over enable)
//   enable   - advance by one when not at the limit
//   limit    - runtime terminal value
//   count    - current count
//   terminal - count equals limit
module md_cycle_counter
  import multdiv_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  assign terminal = (count == limit);

  // Saturates at the limit so the count never wraps while RUN finishes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared iterative multiply/divide datapath.
// Latches an issued op, pulses the datapath load, steps it for a fixed
// number of cycles, then holds the captured result until writeback takes it.
// Ports:
//   clock, reset              - clock (rising edge), async active-low reset
//   ctrl_mult, ctrl_div       - issue from decode (multiply has priority)
//   operandA, operandB        - operands sampled at issue
//   dest_reg                  - destination register sampled at issue
//   md_result_in, md_ovf_in   - datapath result/overflow, final RUN cycle
//   wb_ack                    - writeback consumes the held result
//   md_start, md_op, md_step  - datapath controls
//   md_count                  - datapath iteration index
//   md_a, md_b                - latched operands
//   result, result_reg        - held result and destination
//   result_valid, exception   - result valid / div-by-zero or overflow
//   multdiv_stall             - pipeline freeze request
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [4:0]       dest_reg,
  input  logic [WIDTH-1:0] md_result_in,
  input  logic             md_ovf_in,
  input  logic             wb_ack,
  output logic             md_start,
  output logic             md_op,
  output logic             md_step,
  output logic [CNT_W-1:0] md_count,
  output logic [WIDTH-1:0] md_a,
  output logic [WIDTH-1:0] md_b,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_reg,
  output logic             result_valid,
  output logic             exception,
  output logic             multdiv_stall
);

  localparam logic [CNT_W-1:0] MULT_LIMIT = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LIMIT  = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             issue;
  logic             div_zero;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_clear;
  logic             cnt_term;

  assign issue     = ctrl_mult | ctrl_div;
  assign div_zero  = (md_op == OP_DIV) && (md_b == '0);
  assign cnt_limit = (md_op == OP_DIV) ? DIV_LIMIT : MULT_LIMIT;

  // Held at zero outside RUN so md_count reads 0 during LOAD; left alone
  // in DONE so the final index stays visible with the result.
  assign cnt_clear = (state == ST_IDLE) || (state == ST_LOAD);

  md_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (state == ST_RUN),
    .limit    (cnt_limit),
    .count    (md_count),
    .terminal (cnt_term)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (issue) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = div_zero ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_term) state_nxt = ST_DONE;
      ST_DONE: if (wb_ack) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      md_op      <= OP_MULT;
      md_a       <= '0;
      md_b       <= '0;
      result_reg <= '0;
      result     <= '0;
      exception  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            md_op      <= ctrl_mult ? OP_MULT : OP_DIV;
            md_a       <= operandA;
            md_b       <= operandB;
            result_reg <= dest_reg;
          end
        end
        ST_LOAD: begin
          // Divide by zero short-circuits: the datapath is never stepped.
          if (div_zero) begin
            result    <= '0;
            exception <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cnt_term) begin
            result    <= md_result_in;
            exception <= md_ovf_in;
          end
        end
        ST_DONE: begin
          if (wb_ack) exception <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign md_start     = (state == ST_LOAD);
  assign md_step      = (state == ST_RUN);
  assign result_valid = (state == ST_DONE);
  // Drops in the ack cycle so the pipeline advances on the freeing edge.
  assign multdiv_stall = (state != ST_IDLE) && !((state == ST_DONE) && wb_ack);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Testbench for multdiv_ctrl: a table of directed ops plus randomized ops,
// each checked cycle by cycle against expectations computed from the
// operand values and the documented latency; hand-written reset sequences.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  localparam int WIDTH = 32;
  localparam int MULT_N = 32;
  localparam int DIV_N = 32;
  localparam int CNT_W = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             ctrl_mult = 1'b0;
  logic             ctrl_div = 1'b0;
  logic [WIDTH-1:0] operandA = '0;
  logic [WIDTH-1:0] operandB = '0;
  logic [4:0]       dest_reg = '0;
  logic [WIDTH-1:0] md_result_in = '0;
  logic             md_ovf_in = 1'b0;
  logic             wb_ack = 1'b0;
  logic             md_start, md_op, md_step;
  logic [CNT_W-1:0] md_count;
  logic [WIDTH-1:0] md_a, md_b, result;
  logic [4:0]       result_reg;
  logic             result_valid, exception, multdiv_stall;

  int checks = 0;
  int errors = 0;

  multdiv_ctrl #(
    .WIDTH(WIDTH), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .operandA(operandA), .operandB(operandB), .dest_reg(dest_reg),
    .md_result_in(md_result_in), .md_ovf_in(md_ovf_in), .wb_ack(wb_ack),
    .md_start(md_start), .md_op(md_op), .md_step(md_step), .md_count(md_count),
    .md_a(md_a), .md_b(md_b), .result(result), .result_reg(result_reg),
    .result_valid(result_valid), .exception(exception),
    .multdiv_stall(multdiv_stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_div;
    bit          both;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    bit          ovf;
    int          ack_delay;
    bit          noise;
    logic [31:0] exp_res;
    bit          exp_exc;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " md_start"}, md_start, 0);
    chk({tag, " md_op"}, md_op, 0);
    chk({tag, " md_step"}, md_step, 0);
    chk({tag, " md_count"}, md_count, 0);
    chk({tag, " md_a"}, md_a, 0);
    chk({tag, " md_b"}, md_b, 0);
    chk({tag, " result"}, result, 0);
    chk({tag, " result_reg"}, result_reg, 0);
    chk({tag, " result_valid"}, result_valid, 0);
    chk({tag, " exception"}, exception, 0);
    chk({tag, " stall"}, multdiv_stall, 0);
  endtask

  // Reference behaviour: the op chosen, the datapath value, run length and
  // exception all follow directly from the issue-time operands.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit op = v.both ? 1'b0 : v.is_div;
    if (op && v.b == 0) begin
      r.exp_res = 0;
      r.exp_exc = 1'b1;
    end else begin
      r.exp_res = op ? (v.a / v.b) : (v.a * v.b);
      r.exp_exc = v.ovf;
    end
    return r;
  endfunction

  // Entered at posedge+1 with the DUT in IDLE; leaves it in IDLE.
  task automatic run_op(input string tag, input vec_t v);
    bit op = v.both ? 1'b0 : v.is_div;
    int n = (op && v.b == 0) ? 0 : (op ? DIV_N : MULT_N);
    ctrl_mult = !v.is_div || v.both;
    ctrl_div  = v.is_div || v.both;
    operandA = v.a;
    operandB = v.b;
    dest_reg = v.dest;
    step();  // issue edge
    ctrl_mult = 1'b0;
    ctrl_div = 1'b0;
    chk({tag, " load md_start"}, md_start, 1);
    chk({tag, " load md_count"}, md_count, 0);
    chk({tag, " load md_step"}, md_step, 0);
    chk({tag, " load md_op"}, md_op, op);
    chk({tag, " load md_a"}, md_a, v.a);
    chk({tag, " load md_b"}, md_b, v.b);
    chk({tag, " load stall"}, multdiv_stall, 1);
    chk({tag, " load valid"}, result_valid, 0);
    if (v.noise) begin
      ctrl_div = 1'b1;
      operandA = ~v.a;
      operandB = ~v.b;
    end
    md_result_in = $urandom;
    md_ovf_in = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, " run md_step"}, md_step, 1);
      chk({tag, " run md_count"}, md_count, i);
      chk({tag, " run md_start"}, md_start, 0);
      chk({tag, " run valid"}, result_valid, 0);
      if (i == n - 1) begin
        md_result_in = v.exp_res;
        md_ovf_in = v.ovf;
      end else begin
        md_result_in = $urandom;
        md_ovf_in = 1'($urandom);
      end
    end
    step();  // cycle T+2+N
    md_result_in = $urandom;
    md_ovf_in = 1'($urandom);
    chk({tag, " done valid"}, result_valid, 1);
    chk({tag, " done result"}, result, v.exp_res);
    chk({tag, " done exception"}, exception, v.exp_exc);
    chk({tag, " done result_reg"}, result_reg, v.dest);
    chk({tag, " done stall"}, multdiv_stall, 1);
    chk({tag, " done md_step"}, md_step, 0);
    chk({tag, " done md_a"}, md_a, v.a);
    for (int d = 0; d < v.ack_delay; d++) begin
      step();
      chk({tag, " hold valid"}, result_valid, 1);
      chk({tag, " hold result"}, result, v.exp_res);
      chk({tag, " hold exception"}, exception, v.exp_exc);
      chk({tag, " hold stall"}, multdiv_stall, 1);
    end
    wb_ack = 1'b1;
    if (v.noise) begin
      ctrl_div = 1'b0;
      ctrl_mult = 1'b1;
    end
    #1;
    chk({tag, " ack stall"}, multdiv_stall, 0);
    chk({tag, " ack valid"}, result_valid, 1);
    step();
    wb_ack = 1'b0;
    ctrl_mult = 1'b0;
    ctrl_div = 1'b0;
    chk({tag, " idle valid"}, result_valid, 0);
    chk({tag, " idle stall"}, multdiv_stall, 0);
    chk({tag, " idle exception"}, exception, 0);
    chk({tag, " idle md_start"}, md_start, 0);
    chk({tag, " idle md_a"}, md_a, v.a);
  endtask

  initial begin
    vec_t v;
    //            div both a             b   dest ovf dly noise res           exc
    tbl[0] = '{1'b0, 1'b0, 32'd7,        32'd6,   5'd3,  1'b0, 0, 1'b0, 32'd42,       1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'd100,      32'd0,   5'd9,  1'b0, 1, 1'b0, 32'd0,        1'b1};
    tbl[2] = '{1'b1, 1'b1, 32'd5,        32'd3,   5'd17, 1'b0, 0, 1'b1, 32'd15,       1'b0};
    tbl[3] = '{1'b0, 1'b0, 32'd1000,     32'd3,   5'd31, 1'b0, 5, 1'b0, 32'd3000,     1'b0};
    tbl[4] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'd2,   5'd1,  1'b1, 2, 1'b0, 32'hFFFFFFFE, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 32'd2,        32'd2,   5'd2,  1'b0, 0, 1'b0, 32'd4,        1'b0};
    tbl[6] = '{1'b1, 1'b0, 32'd81,       32'd9,   5'd12, 1'b0, 0, 1'b1, 32'd9,        1'b0};

    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    step();
    chk_all_zero("post-reset");

    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i]);

    // Reset dropped in the middle of RUN aborts the op asynchronously.
    ctrl_mult = 1'b1;
    operandA = 32'd123;
    operandB = 32'd456;
    dest_reg = 5'd7;
    step();
    ctrl_mult = 1'b0;
    repeat (11) step();
    chk("midreset md_count", md_count, 10);
    chk("midreset md_step", md_step, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clock);
    #3;
    reset = 1'b1;
    step();
    chk_all_zero("after-midreset");
    v = '{1'b1, 1'b0, 32'd81, 32'd9, 5'd20, 1'b0, 0, 1'b0, 32'd9, 1'b0};
    run_op("div81/9", v);

    // Randomized ops against the reference model.
    for (int k = 0; k < 20; k++) begin
      v.is_div = 1'($urandom);
      v.both = ($urandom_range(0, 3) == 0);
      v.a = $urandom;
      v.b = ($urandom_range(0, 4) == 0) ? 32'd0 :
            (v.is_div ? 32'($urandom_range(1, 1000)) : $urandom);
      v.dest = 5'($urandom);
      v.ovf = ($urandom_range(0, 3) == 0);
      v.ack_delay = $urandom_range(0, 3);
      v.noise = 1'($urandom);
      v = model(v);
      run_op($sformatf("rand%0d", k), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencer for the shared iterative multiply/divide datapath in the 5-stage pipeline.
- Accepts a mult/div issue from decode and latches the operands and destination register.
- Drives the datapath start and step controls over a fixed cycle count, then captures the result and holds it until writeback accepts it.
- Produces the multdiv_stall level consumed by the hazard/stall unit, and the divide-by-zero/overflow exception flag consumed by writeback.

Parameters:
WIDTH, 32, operand/result width
MULT_CYCLES, 32, RUN cycles for a multiply (>=1)
DIV_CYCLES, 32, RUN cycles for a divide (>=1)
CNT_W, 6, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
ctrl_mult  in  1  decode issues a multiply this cycle
ctrl_div  in  1  decode issues a divide this cycle
operandA  in  WIDTH  multiplicand/dividend
operandB  in  WIDTH  multiplier/divisor
dest_reg  in  5  destination register of the issued op
md_result_in  in  WIDTH  datapath result, valid on the final RUN cycle
md_ovf_in  in  1  datapath overflow, valid on the final RUN cycle
wb_ack  in  1  writeback consumes the held result this cycle
md_start  out  1  one-cycle datapath load pulse
md_op  out  1  0 = multiply, 1 = divide
md_step  out  1  datapath iterate enable
md_count  out  CNT_W  current iteration index
md_a, md_b  out  WIDTH  latched operands to the datapath
result  out  WIDTH  held result
result_reg  out  5  held destination register
result_valid  out  1  result/result_reg/exception are valid
exception  out  1  divide-by-zero or overflow
multdiv_stall  out  1  pipeline freeze request

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs and internal registers are 0.
  - Reset asserted mid-operation aborts the operation; no result is produced.
- States: IDLE, LOAD, RUN, DONE. Two-bit encoding: IDLE=00, LOAD=01, RUN=10, DONE=11.
- IDLE:
  - If ctrl_mult|ctrl_div is high at a rising edge, latch operandA, operandB and dest_reg, set md_op, and go to LOAD.
  - ctrl_mult has priority when both are high (md_op=0).
- LOAD:
  - md_start=1 and md_count=0 for exactly one cycle.
  - Divide with operandB==0: go directly to DONE with result=0 and exception=1. The datapath is never stepped.
  - Otherwise go to RUN.
- RUN:
  - md_step=1; md_count runs 0..N-1 (N = MULT_CYCLES or DIV_CYCLES).
  - At the edge where md_count==N-1: capture md_result_in into result and md_ovf_in into exception, then go to DONE.
- DONE:
  - result_valid=1; outputs hold their values.
  - A wb_ack at a rising edge returns the block to IDLE and clears result_valid and exception.
- Latency: issue edge T puts the block in LOAD for cycle T+1, RUN for cycles T+2..T+1+N, and DONE from cycle T+2+N. A multiply with N=32 therefore shows result_valid 34 cycles after the issue edge.
- multdiv_stall:
  - High in LOAD, RUN and DONE.
  - In DONE it is combinationally low in the cycle wb_ack is high, so the pipeline advances on the same edge that frees the unit.
- Issue while not IDLE: ctrl_mult/ctrl_div are ignored. The stall unit guarantees decode is frozen in that case.
- Issue in the same cycle as a DONE wb_ack: ignored. A new op is accepted only from IDLE.
- The counter never wraps: it is cleared on the LOAD→RUN transition and halts at N-1.
- md_a and md_b stay stable from LOAD through DONE.

Decomposition:
- Package multdiv_pkg:
  - state encoding constants
  - op encoding (OP_MULT=0, OP_DIV=1)
  - default cycle counts
- Sub-module md_cycle_counter:
  - CNT_W-bit up-counter with synchronous clear, enable and terminal-count compare against a runtime limit.
  - Asynchronous active-low reset.

Test Plan:
- Multiply: issue mult with A=7, B=6, datapath model returns 42 → md_start at T+1, md_step for 32 cycles, result_valid=1 and result=42 at T+34, result_reg=dest_reg, multdiv_stall high until the wb_ack cycle.
- Divide by zero: issue div with A=100, B=0 → md_start at T+1, no md_step, DONE at T+2 with exception=1 and result=0.
- Simultaneous: ctrl_mult=ctrl_div=1 → md_op=0 and RUN lasts MULT_CYCLES. A new ctrl_div asserted during RUN is ignored; md_a stays unchanged.
- Held result: withhold wb_ack for 5 cycles after DONE → result, result_valid and multdiv_stall stay stable. On wb_ack, multdiv_stall drops in the same cycle and state=IDLE on the next edge.
- Reset mid-operation: drop reset at RUN count 10 → all outputs 0 immediately (asynchronous). After release, a fresh div 81/9 returns 9 after DIV_CYCLES.
- Overflow: datapath asserts md_ovf_in on the final RUN cycle → exception=1 with result_valid. The next op after wb_ack starts with exception=0.
